// File: rtl/depremuat1_stream_pkg.sv
// Shared tq definitions: coefficient/vector geometry, transform-size codes and
// the segment unsplit used by the forward and inverse reorder blocks.
package depremuat1_stream_pkg;

    localparam int COEF_W    = 16;
    localparam int VEC_LANES = 32;

    // Transform-size codes carried alongside each vector.
    localparam logic [1:0] TS_4  = 2'b00;
    localparam logic [1:0] TS_8  = 2'b01;
    localparam logic [1:0] TS_16 = 2'b10;
    localparam logic [1:0] TS_32 = 2'b11;

    typedef logic signed [COEF_W-1:0] coef_t;
    // Lane k occupies bits [16k+15:16k].
    typedef coef_t [VEC_LANES-1:0] vec_t;

    // One buffered vector together with the size it was captured with.
    typedef struct packed {
        logic [1:0] transize;
        vec_t       data;
    } entry_t;

    // Re-interleave one N-lane segment starting at seg_base: the low half goes
    // to the even slots and the high half to the odd slots. Lanes outside the
    // segment pass through untouched.
    function automatic vec_t unsplit(input vec_t v, input int unsigned seg_base,
                                     input int unsigned n);
        vec_t r;
        r = v;
        for (int unsigned k = 0; k < VEC_LANES / 2; k++) begin
            if (k < n / 2) begin
                r[5'(seg_base + 2 * k)]     = v[5'(seg_base + k)];
                r[5'(seg_base + 2 * k + 1)] = v[5'(seg_base + n / 2 + k)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/depremuat1_stream_if.sv
// Vector-in / beat-out handshake bundle for depremuat1_stream.
// slave = the reorder block's view, master = the surrounding logic's view.
interface depremuat1_stream_if #(
    parameter int LANES = 8
);
    import depremuat1_stream_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_inverse;
    logic [1:0]                in_transize;
    vec_t                      in_data;

    logic                      out_valid;
    logic                      out_ready;
    logic [COEF_W*LANES-1:0]   out_data;
    logic [2:0]                out_beat;
    logic                      out_last;
    logic [1:0]                out_transize;

    modport slave (
        input  in_valid, in_inverse, in_transize, in_data, out_ready,
        output in_ready, out_valid, out_data, out_beat, out_last, out_transize
    );

    modport master (
        output in_valid, in_inverse, in_transize, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_beat, out_last, out_transize
    );

endinterface

// File: rtl/depremuat1_perm.sv
// Combinational 32-lane de-permutation: turns recursive even/odd butterfly
// lane order back into natural coefficient order for the selected size.
module depremuat1_perm
    import depremuat1_stream_pkg::*;
(
    input  logic       inverse,
    input  logic [1:0] transize,
    input  vec_t       data_in,
    output vec_t       data_out
);

    // Undo the interleave level by level, innermost (8-lane) level first.
    always_comb begin
        // NOTE: default assignment first and blocking '=' throughout, so every
        // path drives data_out and no latch is inferred.
        data_out = data_in;
        if (inverse) begin
            case (transize)
                TS_8: begin
                    for (int unsigned s = 0; s < 4; s++)
                        data_out = unsplit(data_out, s * 8, 8);
                end
                TS_16: begin
                    for (int unsigned s = 0; s < 2; s++)
                        data_out = unsplit(unsplit(data_out, s * 16, 8), s * 16, 16);
                end
                TS_32: begin
                    data_out = unsplit(unsplit(unsplit(data_out, 0, 8), 0, 16), 0, 32);
                end
                default: ;  // 4-point vectors are already in natural order
            endcase
        end
    end

endmodule

// File: rtl/depremuat1_stream.sv
// depremuat1_stream: captures one 32-coefficient vector, restores natural
// order on the write path and drains it as BEATS = 32/LANES beats.
// Build option: DEPREMUAT_PINGPONG_EN gives a two-entry buffer so a new vector
// can be accepted while the other one drains; otherwise one entry is used.
module depremuat1_stream
    import depremuat1_stream_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                clk,
    input  logic                rst,
    depremuat1_stream_if.slave  bus
);

`ifdef DEPREMUAT_PINGPONG_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int         BEATS     = VEC_LANES / LANES;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    logic [1:0] count;
    logic [2:0] beat;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       accept;
    logic       beat_done;
    logic       pop;
    vec_t       perm_data;
    entry_t     head;
    logic [4:0] base_lane;
    entry_t     mem [DEPTH];

    depremuat1_perm u_perm (
        .inverse  (bus.in_inverse),
        .transize (bus.in_transize),
        .data_in  (bus.in_data),
        .data_out (perm_data)
    );

    // A full buffer only reopens on the cycle after the pop; no bypass path.
    assign bus.in_ready  = (count < 2'(DEPTH));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (count != 2'd0);
    assign beat_done     = bus.out_valid && bus.out_ready;
    assign pop           = beat_done && (beat == LAST_BEAT);

    // Store the already-reordered vector so the read side is a plain slice.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; an entry is only read while count marks
        // it full, and the outputs below are forced to zero when empty.
        if (accept)
            mem[wr_ptr] <= '{transize: bus.in_transize, data: perm_data};
    end

    // Occupancy, pointers and beat position.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking '<=' for all state so every flop sees the
        // pre-edge values of the others.
        if (rst) begin
            count  <= 2'd0;
            beat   <= 3'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= (DEPTH > 1) ? ~wr_ptr : 1'b0;
            if (pop)
                rd_ptr <= (DEPTH > 1) ? ~rd_ptr : 1'b0;
            if (beat_done)
                beat <= (beat == LAST_BEAT) ? 3'd0 : beat + 3'd1;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Present the current beat of the head entry; all zero while empty.
    always_comb begin
        base_lane        = 5'(int'(beat) * LANES);
        bus.out_data     = '0;
        bus.out_transize = 2'b00;
        if (bus.out_valid) begin
            bus.out_data     = head.data[base_lane +: LANES];
            bus.out_transize = head.transize;
        end
    end

    assign bus.out_beat = beat;
    assign bus.out_last = bus.out_valid && (beat == LAST_BEAT);

endmodule

// File: tb/tb_depremuat1_stream.sv
// Self-checking bench for depremuat1_stream (LANES = 8): directed table,
// multi-cycle corner sequences and randomized traffic against a scoreboard.
`timescale 1ns/1ps
module tb_depremuat1_stream;
    import depremuat1_stream_pkg::*;

    localparam int LANES = 8;
    localparam int BEATS = 32 / LANES;
`ifdef DEPREMUAT_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    depremuat1_stream_if #(.LANES(LANES)) bus();
    depremuat1_stream #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        vec_t       data;
        logic [1:0] transize;
    } exp_vec_t;

    exp_vec_t     sb[$];
    int           exp_beat = 0;
    int           handshakes = 0;
    int           cyc = 0;
    int           hs_cyc[$];
    logic         stalled = 1'b0;
    logic [127:0] held_data;
    logic [2:0]   held_beat;
    logic         held_last;

    typedef struct {
        logic         inv;
        logic [1:0]   ts;
        logic [127:0] beat0;
        logic [127:0] beat1;
    } tbl_t;
    tbl_t tbl[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
        logic [127:0] r;
        r = {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return r;
    endfunction

    function automatic vec_t ramp();
        vec_t v;
        for (int k = 0; k < 32; k++) v[k] = 16'(k);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < 32; k++) v[k] = 16'($urandom);
        return v;
    endfunction

    // Reference: rebuild the forward even/odd split that produced the
    // received lane order (outermost level first), then scatter each received
    // lane to the natural index it carries.
    function automatic vec_t model(input logic inv, input logic [1:0] ts, input vec_t v);
        int   held[32];
        int   tmp[32];
        int   sb_base[$];
        int   sb_n[$];
        vec_t r;
        for (int i = 0; i < 32; i++) held[i] = i;
        if (inv) begin
            case (ts)
                2'b01: for (int s = 0; s < 4; s++) begin sb_base.push_back(8 * s); sb_n.push_back(8); end
                2'b10: for (int s = 0; s < 2; s++) begin
                    sb_base.push_back(16 * s); sb_n.push_back(16);
                    sb_base.push_back(16 * s); sb_n.push_back(8);
                end
                2'b11: begin
                    sb_base.push_back(0); sb_n.push_back(32);
                    sb_base.push_back(0); sb_n.push_back(16);
                    sb_base.push_back(0); sb_n.push_back(8);
                end
                default: ;
            endcase
        end
        for (int s = 0; s < sb_base.size(); s++) begin
            tmp = held;
            for (int k = 0; k < sb_n[s] / 2; k++) begin
                held[sb_base[s] + k]             = tmp[sb_base[s] + 2 * k];
                held[sb_base[s] + sb_n[s] / 2 + k] = tmp[sb_base[s] + 2 * k + 1];
            end
        end
        r = '0;
        for (int l = 0; l < 32; l++) r[5'(held[l])] = v[l];
        return r;
    endfunction

    // One clock: score the handshakes the coming edge will perform, verify
    // stall stability, then advance to just after the edge.
    task automatic tick();
        logic [127:0] exp_w;
        vec_t         hv;
        exp_vec_t     e;
        if (stalled) begin
            check("stall_valid", 128'(bus.out_valid), 128'(1));
            check("stall_data", bus.out_data, held_data);
            check("stall_beat", 128'(bus.out_beat), 128'(held_beat));
            check("stall_last", 128'(bus.out_last), 128'(held_last));
        end
        if (bus.in_valid && bus.in_ready) begin
            e.data     = model(bus.in_inverse, bus.in_transize, bus.in_data);
            e.transize = bus.in_transize;
            sb.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
            handshakes++;
            hs_cyc.push_back(cyc);
            check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                hv    = sb[0].data;
                exp_w = hv[exp_beat * LANES +: LANES];
                check("beat_data", bus.out_data, exp_w);
                check("beat_index", 128'(bus.out_beat), 128'(exp_beat));
                check("beat_last", 128'(bus.out_last), 128'(exp_beat == BEATS - 1));
                check("beat_transize", 128'(bus.out_transize), 128'(sb[0].transize));
                exp_beat++;
                if (exp_beat == BEATS) begin
                    exp_beat = 0;
                    void'(sb.pop_front());
                end
            end
        end
        stalled   = bus.out_valid && !bus.out_ready;
        held_data = bus.out_data;
        held_beat = bus.out_beat;
        held_last = bus.out_last;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int   low;
        int   hs0;
        int   n;
        int   sent;
        bit   pend;
        bit   acc;

        tbl[0] = '{1'b1, 2'b01, mk8(0, 4, 1, 5, 2, 6, 3, 7),     mk8(8, 12, 9, 13, 10, 14, 11, 15)};
        tbl[1] = '{1'b1, 2'b11, mk8(0, 16, 8, 17, 4, 18, 9, 19), mk8(1, 20, 10, 21, 5, 22, 11, 23)};
        tbl[2] = '{1'b1, 2'b00, mk8(0, 1, 2, 3, 4, 5, 6, 7),     mk8(8, 9, 10, 11, 12, 13, 14, 15)};
        tbl[3] = '{1'b0, 2'b11, mk8(0, 1, 2, 3, 4, 5, 6, 7),     mk8(8, 9, 10, 11, 12, 13, 14, 15)};
        tbl[4] = '{1'b1, 2'b10, mk8(0, 8, 4, 9, 1, 10, 5, 11),   mk8(2, 12, 6, 13, 3, 14, 7, 15)};

        bus.in_valid    = 1'b0;
        bus.in_inverse  = 1'b0;
        bus.in_transize = 2'b00;
        bus.in_data     = rand_vec();
        bus.out_ready   = 1'b0;
        rst             = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_last", 128'(bus.out_last), 128'(0));
        check("rst_out_beat", 128'(bus.out_beat), 128'(0));
        check("rst_out_transize", 128'(bus.out_transize), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: ramp vectors, full-speed drain.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_inverse  = tbl[i].inv;
            bus.in_transize = tbl[i].ts;
            bus.in_data     = ramp();
            bus.out_ready   = 1'b1;
            check("tbl_in_ready", 128'(bus.in_ready), 128'(1));
            tick();
            bus.in_valid = 1'b0;
            bus.in_data  = rand_vec();
            for (int b = 0; b < BEATS; b++) begin
                check("tbl_valid", 128'(bus.out_valid), 128'(1));
                check("tbl_beat", 128'(bus.out_beat), 128'(b));
                check("tbl_last", 128'(bus.out_last), 128'(b == BEATS - 1));
                check("tbl_transize", 128'(bus.out_transize), 128'(tbl[i].ts));
                if (b == 0) check("tbl_beat0", bus.out_data, tbl[i].beat0);
                if (b == 1) check("tbl_beat1", bus.out_data, tbl[i].beat1);
                tick();
            end
            check("tbl_drained", 128'(bus.out_valid), 128'(0));
        end

        // Consumer stalls: out_ready pattern 1,0,0,1.
        bus.in_valid    = 1'b1;
        bus.in_inverse  = 1'b1;
        bus.in_transize = TS_8;
        bus.in_data     = ramp();
        bus.out_ready   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        hs0 = handshakes;
        n   = 0;
        while (handshakes - hs0 < BEATS && n < 40) begin
            bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        check("stall_delivered", 128'(handshakes - hs0), 128'(BEATS));
        check("stall_drained", 128'(bus.out_valid), 128'(0));

        // Two back-to-back vectors with the consumer always ready.
        hs_cyc.delete();
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_inverse  = 1'b1;
        bus.in_transize = TS_32;
        bus.in_data     = rand_vec();
        check("b2b_first_ready", 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_inverse  = 1'b0;
        bus.in_transize = TS_16;
        bus.in_data     = rand_vec();
        low = 0;
        while (!bus.in_ready && low < 20) begin
            tick();
            low++;
        end
        check("b2b_ready_low_cycles", 128'(low), 128'(PINGPONG ? 0 : BEATS));
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("b2b_beats", 128'(hs_cyc.size()), 128'(2 * BEATS));
        if (hs_cyc.size() == 2 * BEATS)
            check("b2b_span", 128'(hs_cyc[2 * BEATS - 1] - hs_cyc[0]),
                  128'(PINGPONG ? 2 * BEATS - 1 : 2 * BEATS));

        // Reset in the middle of a drain, after beat 1.
        bus.in_valid    = 1'b1;
        bus.in_inverse  = 1'b1;
        bus.in_transize = TS_8;
        bus.in_data     = ramp();
        bus.out_ready   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("rst_mid_pre_beat", 128'(bus.out_beat), 128'(2));
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 128'(bus.out_valid), 128'(0));
        check("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_mid_beat", 128'(bus.out_beat), 128'(0));
        check("rst_mid_last", 128'(bus.out_last), 128'(0));
        check("rst_mid_data", bus.out_data, 128'(0));
        sb.delete();
        exp_beat = 0;
        stalled  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_residual", 128'(bus.out_valid), 128'(0));
        bus.in_valid    = 1'b1;
        bus.in_inverse  = 1'b1;
        bus.in_transize = TS_4;
        bus.in_data     = ramp();
        tick();
        bus.in_valid = 1'b0;
        check("rst_next_beat", 128'(bus.out_beat), 128'(0));
        check("rst_next_data", bus.out_data, mk8(0, 1, 2, 3, 4, 5, 6, 7));
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end

        // Randomized traffic against the scoreboard.
        sent = 0;
        pend = 1'b0;
        n    = 0;
        while ((sent < 40 || sb.size() != 0) && n < 5000) begin
            if (!pend && sent < 40 && $urandom_range(0, 99) < 60) begin
                pend            = 1'b1;
                bus.in_valid    = 1'b1;
                bus.in_inverse  = 1'($urandom_range(0, 1));
                bus.in_transize = 2'($urandom_range(0, 3));
                bus.in_data     = rand_vec();
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
            acc = pend && bus.in_ready;
            tick();
            if (acc) begin
                pend         = 1'b0;
                bus.in_valid = 1'b0;
                bus.in_data  = rand_vec();
                sent++;
            end
            n++;
        end
        check("rand_complete", 128'(sent == 40 && sb.size() == 0), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/depremuat1_stream.md
# depremuat1_stream

Output-side counterpart of the inverse-transform input permutation in the tq path. The block accepts one 32-coefficient vector whose lanes are in recursive even/odd butterfly order and restores natural coefficient order. It buffers the vector and streams it out in fixed-width beats under valid/ready handshakes, so it can sit between a transform core and a downstream consumer with a narrower data path. A transform-size field selects how far the recursive interleave is applied.

## Interface
Parameters:
- LANES, 8, coefficients per output beat; legal values 4, 8, 16; BEATS = 32/LANES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_inverse  in  1  1 = de-permute; 0 = pass through unchanged.
- in_transize  in  2  00=4pt, 01=8pt, 10=16pt, 11=32pt.
- in_data  in  512  lane k at bits [16k+15:16k], signed 16-bit.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  16*LANES  beat lanes, lane j = natural index beat*LANES+j.
- out_beat  out  3  beat index 0..BEATS-1.
- out_last  out  1  high on beat BEATS-1.
- out_transize  out  2  transize of vector being drained.

## Operation
- Definitions, applied to a segment of N lanes:
  - unsplit_N: out[2k] = in[k]; out[2k+1] = in[N/2+k], for k < N/2.
  - Segments never overlap.
- Permutation is applied at capture when in_inverse=1, and depends on in_transize:
  - 00: identity.
  - 01: unsplit_8 on each of lanes 0-7, 8-15, 16-23, 24-31.
  - 10: on each 16-lane half, first unsplit_8 on its low 8 lanes, then unsplit_16 on the half.
  - 11: unsplit_8 on lanes 0-7, then unsplit_16 on 0-15, then unsplit_32 on 0-31.
- in_inverse=0: stored unchanged regardless of transize.
- Pure data movement: no arithmetic; sign and width preserved.
- Buffer:
  - DEPTH entries (see Configuration), each holding the permuted 512-bit vector plus transize.
  - count = number of full entries; rd/wr pointers.
- Accept: in_valid & in_ready. in_ready = (count < DEPTH), combinational from flops.
- Drain:
  - out_valid = (count != 0).
  - out_data selects the head entry slice [beat*LANES*16 +: LANES*16].
  - On out_valid & out_ready, beat increments; on the last beat, beat wraps to 0, the head entry is freed and rd pointer advances.
- Simultaneous accept and last-beat pop: count unchanged, both pointers advance.
- A full buffer freeing an entry does not raise in_ready until the next cycle; there is no same-cycle bypass.

## Timing
- Reset values: count=0, beat=0, pointers=0, out_valid=0, out_last=0, out_beat=0, out_transize=0, out_data=0, in_ready=1.
- Latency: vector accepted at edge T, beat 0 valid after edge T (visible in cycle T+1).
- Drain: BEATS consecutive cycles when out_ready is held high.
- out_ready low: out_data, out_beat, out_last and out_valid hold stable; no beat is skipped.
- Reset asserted mid-drain: all state clears immediately; partial vectors are discarded with no residual beats.
- in_data is sampled only on accept; it is don't-care otherwise.

## Configuration
- DEPREMUAT_PINGPONG_EN defined:
  - DEPTH=2.
  - A new vector is accepted while the other entry drains.
  - Sustained throughput is 1 vector per BEATS cycles.
- Not defined:
  - DEPTH=1; in_ready low from accept until the last beat pops.
  - Sustained accept period is BEATS+1 cycles.

## Structure
- Shared tq package:
  - transize encoding constants TS_4, TS_8, TS_16, TS_32.
  - coefficient width 16.
  - vector lane count 32.
  - a permutation function unsplit(seg_base, N) usable by both forward and inverse reorder blocks.
- One natural sub-module: depremuat1_perm, a combinational 32-lane de-permutation of (inverse, transize, data), instantiated on the write path.

## Test plan
- Size 8, inverse=1, lane k=k, LANES=8, out_ready=1 -> beat0 = 0,4,1,5,2,6,3,7; beat1 = 8,12,9,13,10,14,11,15; out_last on beat3.
- Size 32, inverse=1, lane k=k -> beat0 = 0,16,8,17,4,18,9,19; out_transize=11.
- Size 4 with inverse=1, and size 32 with inverse=0, lane k=k -> beat0 = 0..7 unchanged.
- out_ready toggled 1,0,0,1 during drain -> each beat held stable while stalled; 4 distinct beats delivered in order; none lost or duplicated.
- Two back-to-back vectors with out_ready=1:
  - With DEPREMUAT_PINGPONG_EN, in_ready stays high and out_valid is continuous for 8 cycles.
  - Without it, in_ready is low for 4 cycles and the second accept occurs 5 cycles after the first.
- rst pulsed after beat1 of a vector -> out_valid=0, in_ready=1 next cycle; the following vector starts at out_beat=0.
